// File: rtl/imem_loader_if.sv
// Byte stream and memory write port bundle for the boot-time image loader.
// The loader is the slave: it consumes rx bytes and drives the write port.
interface imem_loader_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8
);
    logic                     rx_valid;
    logic [DATA_WIDTH-1:0]    rx_data;
    logic                     rx_ready;
    logic                     WE;
    logic [ADDRESS_WIDTH-1:0] WA;
    logic [DATA_WIDTH-1:0]    WD;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, WE, WA, WD
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, WE, WA, WD
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: length header, payload, checksum trailer.
// Holds the core in reset until a verified image sits in memory.
module imem_loader #(
    parameter int ADDRESS_WIDTH      = 32,
    parameter int ADDRESS_REAL_WIDTH = 12,
    parameter int DATA_WIDTH         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_rst_n
);
    localparam int AW = ADDRESS_REAL_WIDTH;
    localparam logic [32:0] CAP = 33'd1 << AW;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               hcnt_q, hcnt_d;
    logic [31:0]              len_q, len_d;
    logic [AW:0]              addr_q, addr_d;
    logic [AW:0]              addr_inc;
    logic [DATA_WIDTH-1:0]    sum_q, sum_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     cpu_q, cpu_d;
    logic                     rdy;
    logic                     acc;

    assign rdy      = (state_q == HDR) || (state_q == LOAD) || (state_q == CHECK);
    assign acc      = rdy && bus.rx_valid;
    assign addr_inc = addr_q + {{AW{1'b0}}, 1'b1};

    assign bus.rx_ready = rdy;
    assign bus.WE       = we_q;
    assign bus.WA       = wa_q;
    assign bus.WD       = wd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_rst_n    = cpu_q;

    // Next state, datapath updates and registered status decodes
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = HDR;
                    hcnt_d  = 2'd0;
                    len_d   = 32'd0;
                    sum_d   = '0;
                end
            end
            HDR: begin
                if (acc) begin
                    len_d  = {bus.rx_data, len_q[31:DATA_WIDTH]};
                    hcnt_d = 2'(hcnt_q + 2'd1);
                    if (hcnt_q == 2'd3) begin
                        if (len_d == 32'd0) begin
                            state_d = CHECK;
                        end else if ({1'b0, len_d} > CAP) begin
                            state_d = ERROR;
                        end else begin
                            state_d = LOAD;
                            addr_d  = '0;
                        end
                    end
                end
            end
            LOAD: begin
                if (acc) begin
                    we_d   = 1'b1;
                    wa_d   = ADDRESS_WIDTH'(addr_q);
                    wd_d   = bus.rx_data;
                    sum_d  = sum_q + bus.rx_data;
                    addr_d = addr_inc;
                    if (32'(addr_inc) == len_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (acc) begin
                    state_d = (bus.rx_data == sum_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == HDR) || (state_d == LOAD) || (state_d == CHECK);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERROR);
        cpu_d   = (state_d == DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= 2'd0;
            len_q   <= 32'd0;
            addr_q  <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cpu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            cpu_q   <= cpu_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the
// driver and popped by a monitor whenever WE is seen.
module tb_imem_loader;
    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, error, cpu_rst_n;

    int checks = 0;
    int errors = 0;
    wr_t exp_q[$];
    logic [31:0] exp_addr;
    logic [7:0]  sum;

    imem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8)) bus ();

    imem_loader #(
        .ADDRESS_WIDTH(32),
        .ADDRESS_REAL_WIDTH(12),
        .DATA_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .error(error),
        .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must match the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got WA=%0h WD=%0h expected none",
                         bus.WA, bus.WD);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_WA", bus.WA, e.a);
                chk("write_WD", {24'd0, bus.WD}, {24'd0, e.d});
            end
        end
    end

    // Present one byte at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] len);
        send(len[7:0]);
        send(len[15:8]);
        send(len[23:16]);
        send(len[31:24]);
    endtask

    task automatic pay(input logic [7:0] b);
        exp_q.push_back('{a: exp_addr, d: b});
        exp_addr = exp_addr + 32'd1;
        sum = sum + b;
        send(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 32'd0;
        sum = 8'd0;
    endtask

    task automatic drain(input string name);
        repeat (2) @(negedge clk);
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic status(input string name, input logic b, input logic d,
                          input logic e, input logic c);
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_error"}, {31'd0, error}, {31'd0, e});
        chk({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, c});
    endtask

    task automatic nominal(input logic [7:0] trailer);
        send_hdr(32'd4);
        pay(8'h93);
        pay(8'h00);
        pay(8'h10);
        pay(8'h00);
        send(trailer);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stall_d [8];
        int stall_g [8];
        stall_d = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
        stall_g = '{0, 2, 1, 3, 0, 1, 2, 0};
        rst_n = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        exp_addr = 32'd0;
        sum = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("rst_WE", {31'd0, bus.WE}, 32'd0);
        chk("rst_WA", bus.WA, 32'd0);
        chk("rst_WD", {24'd0, bus.WD}, 32'd0);
        status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle with rx_valid high and no start
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h55;
        repeat (8) begin
            @(negedge clk);
            chk("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
            chk("idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        end
        bus.rx_valid = 1'b0;

        // Nominal load
        pulse_start();
        chk("nom_busy_after_start", {31'd0, busy}, 32'd1);
        nominal(8'hA3);
        status("nom", 1'b0, 1'b1, 1'b0, 1'b1);
        drain("nom_drain");

        // Checksum failure, then recovery
        pulse_start();
        status("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        nominal(8'hA4);
        status("cks", 1'b0, 1'b0, 1'b1, 1'b0);
        drain("cks_drain");
        pulse_start();
        nominal(8'hA3);
        status("recover", 1'b0, 1'b1, 1'b0, 1'b1);
        drain("recover_drain");

        // Overflow header 4097
        pulse_start();
        send_hdr(32'h0000_1001);
        status("ovf", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        drain("ovf_drain");

        // Maximum length 4096
        pulse_start();
        send_hdr(32'h0000_1000);
        for (int i = 0; i < 4096; i++) begin
            pay(i[7:0]);
        end
        chk("max_last_addr", exp_addr, 32'd4096);
        send(sum);
        status("max", 1'b0, 1'b1, 1'b0, 1'b1);
        drain("max_drain");

        // Stalls with ignored start pulses
        pulse_start();
        send_hdr(32'd8);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < stall_g[i]; g++) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("stall_busy", {31'd0, busy}, 32'd1);
            end
            pay(stall_d[i]);
        end
        chk("stall_sum", {24'd0, sum}, 32'h65);
        send(sum);
        status("stall", 1'b0, 1'b1, 1'b0, 1'b1);
        drain("stall_drain");

        // Zero length image
        pulse_start();
        send_hdr(32'd0);
        send(8'h00);
        status("zero", 1'b0, 1'b1, 1'b0, 1'b1);
        drain("zero_drain");

        // Asynchronous reset after two payload bytes
        pulse_start();
        send_hdr(32'd4);
        pay(8'h93);
        pay(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_WE", {31'd0, bus.WE}, 32'd0);
        chk("arst_WA", bus.WA, 32'd0);
        chk("arst_WD", {24'd0, bus.WD}, 32'd0);
        chk("arst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        status("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        nominal(8'hA3);
        status("after_rst", 1'b0, 1'b1, 1'b0, 1'b1);
        drain("after_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
